// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and datapath-select encodings for mc_control (MC_CTRL_ADDI_EN adds addi)
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Successor of DECODE; S_FETCH doubles as the "unsupported opcode" marker.
  function automatic logic [3:0] dispatch(input logic [5:0] op);
    logic [3:0] nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI:      nxt = S_ADDIEX;
`endif
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational per-state strobe decode (ADDI states under MC_CTRL_ADDI_EN)
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic       nrst,
  input  logic [3:0] state,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
);

  // Gating on nrst here kills any in-flight write strobe the instant reset asserts.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUOp    = ALUOP_ADD;
    PCSource = PCSRC_ALU;
    if (nrst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_SUB;
          PCSource = PCSRC_ALUOUT;
          PCWrite  = zero;
        end
        S_JUMP: begin
          PCSource = PCSRC_JUMP;
          PCWrite  = 1'b1;
        end
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        S_ADDIWB: RegWrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main control FSM top (addi path under MC_CTRL_ADDI_EN)
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // MEMADR relies on op still reflecting IR, which only reloads in FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dispatch(op);
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state      = nrst ? state_q : S_FETCH;
  assign illegal_op = nrst && (state_q == S_DECODE) && (dispatch(op) == S_FETCH);

  mc_ctrl_decode u_decode (
    .nrst     (nrst),
    .state    (state_q),
    .zero     (zero),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSource (PCSource)
  );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control against an instruction-path model
module tb_mc_control;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] op;
  logic       zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int path[$];

  mc_control dut (
    .clk(clk), .nrst(nrst), .op(op), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  function automatic bit addi_on();
`ifdef MC_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return (o == 6'h23) || (o == 6'h2B) || (o == 6'h00) || (o == 6'h04) || (o == 6'h02) ||
           (addi_on() && o == 6'h08);
  endfunction

  // States visited after FETCH, before returning to FETCH.
  function automatic void fill_path(input logic [5:0] o);
    path.delete();
    path.push_back(1);
    if (o == 6'h23)      begin path.push_back(2); path.push_back(3); path.push_back(4); end
    else if (o == 6'h2B) begin path.push_back(2); path.push_back(5); end
    else if (o == 6'h00) begin path.push_back(6); path.push_back(7); end
    else if (o == 6'h04) path.push_back(8);
    else if (o == 6'h02) path.push_back(9);
    else if (addi_on() && o == 6'h08) begin path.push_back(10); path.push_back(11); end
  endfunction

  function automatic logic [16:0] expect_out(input int st, input logic [5:0] o, input logic z);
    logic pcw, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    {pcw, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; end
      1:  begin sb = 2'b11; ill = !legal(o); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = z; end
      9:  begin ps = 2'b10; pcw = 1; end
      10: if (addi_on()) begin sa = 1; sb = 2'b10; end
      11: if (addi_on()) rw = 1;
      default: ;
    endcase
    return {pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+2 in FETCH; zsel<0 means random zero with a mid-BRANCH toggle.
  task automatic run_instr(input logic [5:0] o, input int zsel);
    op = o;
    fill_path(o);
    chk("fetch_out", obs, expect_out(0, o, zero));
    chk("fetch_state", {13'd0, state}, 17'd0);
    foreach (path[i]) begin
      @(posedge clk);
      zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      #2;
      chk($sformatf("state op=%h step=%0d", o, i), {13'd0, state}, 17'(path[i]));
      chk($sformatf("out op=%h st=%0d", o, path[i]), obs, expect_out(path[i], o, zero));
      if (path[i] == 8 && zsel < 0) begin
        zero = ~zero;
        #1;
        chk("branch_zero_toggle", obs, expect_out(8, o, zero));
      end
    end
    @(posedge clk);
    #2;
    chk($sformatf("return op=%h", o), {13'd0, state}, 17'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pool [6];
    pool[0] = 6'h23; pool[1] = 6'h2B; pool[2] = 6'h00;
    pool[3] = 6'h04; pool[4] = 6'h02; pool[5] = 6'h08;
    nrst = 1'b0; op = 6'h3F; zero = 1'b1;

    repeat (3) begin
      @(posedge clk);
      #2;
      chk("reset_out", obs, 17'd0);
      chk("reset_state", {13'd0, state}, 17'd0);
    end
    nrst = 1'b1;
    #1;
    chk("release_fetch", obs, expect_out(0, op, zero));
    #1;

    run_instr(6'h23, 0);
    run_instr(6'h04, 1);
    run_instr(6'h04, 0);
    run_instr(6'h02, 0);
    run_instr(6'h3F, 0);
    run_instr(6'h08, 0);
    run_instr(6'h2B, 1);
    run_instr(6'h00, 0);

    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 3) == 0) run_instr(6'($urandom_range(0, 63)), -1);
      else run_instr(pool[$urandom_range(0, 5)], -1);
    end

    // Reset during MEMWR of a sw must drop MemWrite at once.
    op = 6'h2B;
    repeat (3) @(posedge clk);
    #2;
    chk("sw_memwr_state", {13'd0, state}, 17'd5);
    chk("sw_memwr_out", obs, expect_out(5, op, zero));
    nrst = 1'b0;
    #1;
    chk("midreset_out", obs, 17'd0);
    chk("midreset_state", {13'd0, state}, 17'd0);
    @(posedge clk);
    #2;
    chk("midreset_hold", obs, 17'd0);
    nrst = 1'b1;
    #1;
    chk("midreset_release", obs, expect_out(0, op, zero));
    #1;
    run_instr(6'h23, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath. Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles. Drives every datapath strobe, including `PCWrite`, `PCSource` and `IorD`. It sits directly upstream of the PC register and PC-source mux, and consumes the opcode from the instruction register and `zero` from the ALU.

## Interface

No parameters.

- `clk`  in  1  system clock; state register updates on posedge
- `nrst`  in  1  reset nrst, asynchronous, active-low
- `op`  in  6  opcode, IR[31:26]
- `zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC load enable (unconditional, or branch-taken)
- `IorD`  out  1  memory address select: 0=PC, 1=ALUOut
- `MemRead`  out  1  memory read strobe
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  1  register write data: 0=ALUOut, 1=MDR
- `RegDst`  out  1  destination register: 0=rt, 1=rd
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  ALU A input: 0=PC, 1=A
- `ALUSrcB`  out  2  ALU B input: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
- `ALUOp`  out  2  00=add, 01=sub, 10=funct-decoded
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target
- `illegal_op`  out  1  high for the DECODE cycle of an unsupported opcode
- `state`  out  4  current state encoding, for debug

## Operation

- States, with encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
- Transitions:
  - FETCH → DECODE.
  - DECODE, by `op`:
    - 0x23 (lw) or 0x2B (sw) → MEMADR.
    - 0x00 (R-type) → EXEC.
    - 0x04 (beq) → BRANCH.
    - 0x02 (j) → JUMP.
    - Any other opcode → FETCH, with `illegal_op`=1.
  - MEMADR → MEMRD if lw, MEMWR if sw. Uses the `op` held in IR.
  - MEMRD → MEMWB. EXEC → RWB.
  - MEMWB, MEMWR, RWB, BRANCH and JUMP → FETCH.
  - Undefined encodings 12–15 → FETCH.
- Outputs are Moore, except `PCWrite` in BRANCH, which is combinational on `zero`. Every strobe not listed for a state is 0; `ALUSrcB`, `ALUOp` and `PCSource` default to 00.
- Per-state outputs:
  - FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01.
  - DECODE: ALUSrcB=11. Precomputes the branch target into ALUOut.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWrite=`zero`.
  - JUMP: PCSource=10, PCWrite=1.
- `illegal_op` is a one-cycle pulse. It does not stall or trap.

## Timing

- The state register is clocked on posedge. The PC register loads on the following negedge, so `PCWrite`, `PCSource` and `zero` must settle within half a cycle.
- While `nrst`=0:
  - State is FETCH.
  - All outputs are forced to 0, gated combinationally by `nrst`.
  - `state` reads 0.
- After `nrst` deasserts, FETCH outputs are live immediately.
- Reset asserted mid-instruction returns to FETCH asynchronously. No partial write completes after the assertion.
- Instruction latencies, FETCH to FETCH: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- `zero` toggling during BRANCH propagates directly to `PCWrite`. The value present at the negedge is the one that counts.

## Configuration

- `MC_CTRL_ADDI_EN`:
  - Defined: DECODE maps 0x08 (addi) → ADDIEX → ADDIWB → FETCH, 4 cycles.
    - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
    - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - Undefined: 0x08 is illegal, and encodings 10–11 are treated as undefined (→ FETCH).

## Structure

- Package `mc_pkg` holds:
  - state encodings;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`;
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings.
- Sub-module `mc_ctrl_decode` is purely combinational: state, `zero` and `nrst` in, all strobes out. The top-level module holds the state register and next-state logic.

## Test plan

- Reset and release:
  - Hold `nrst`=0 for 3 cycles → all outputs 0, `state`=0.
  - Release → `MemRead`=`IRWrite`=`PCWrite`=1, `ALUSrcB`=01.
- lw (`op`=0x23):
  - States 0,1,2,3,4 on successive posedges.
  - MEMRD has `IorD`=1, `MemRead`=1.
  - MEMWB has `RegWrite`=`MemtoReg`=1.
  - Back in FETCH at cycle 5.
- beq (`op`=0x04):
  - `zero`=1 → `PCWrite`=1, `PCSource`=01 in state 8.
  - Repeat with `zero`=0 → `PCWrite`=0.
  - Both return to FETCH after 3 cycles.
- j (`op`=0x02) → state 9, `PCWrite`=1, `PCSource`=10, then FETCH.
- Illegal opcode:
  - `op`=0x3F → `illegal_op`=1 in DECODE only, next state 0.
  - With `MC_CTRL_ADDI_EN`, `op`=0x08 → states 0,1,10,11,0 and `RegWrite`=1, `RegDst`=0 in state 11.
- Reset mid-instruction: assert `nrst` during MEMWR (`op`=0x2B) → `MemWrite` drops to 0 immediately, `state`=0.
